// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer with optional MM:SS digits, held-key auto-repeat, pause/resume
// and a preset that is restored after the count finishes or is aborted.
module bcd_countdown_timer #(
    parameter int DIGITS       = 4,
    parameter int MODE_MMSS    = 1,
    parameter int CLK_HZ       = 12000000,
    parameter int REPEAT_DELAY = 6000000,
    parameter int REPEAT_RATE  = 1200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  plus,
    input  logic                  minus,
    input  logic                  start,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   display,
    output logic                  running,
    output logic                  paused,
    output logic                  done,
    output logic                  finish
);

    localparam int VW   = 4 * DIGITS;
    localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

    // Tens-of-seconds digit only reaches 5 in MM:SS mode.
    function automatic logic [3:0] dig_lim(input int d);
        return (MODE_MMSS != 0 && d == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [VW-1:0] max_val();
        logic [VW-1:0] v;
        v = '0;
        for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = dig_lim(d);
        return v;
    endfunction

    localparam logic [VW-1:0] VMAX = max_val();

    function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (r[4*d +: 4] == dig_lim(d)) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return (v == VMAX) ? v : r;
    endfunction

    function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (b) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = dig_lim(d);
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return (v == '0) ? v : r;
    endfunction

    state_e        state_q, state_d;
    logic [VW-1:0] value_q, value_d;
    logic [VW-1:0] preset_q, preset_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_fast_q, rpt_fast_d;
    logic          finish_q, finish_d;
    logic [3:0]    btn_q, btn_d;

    logic [3:0]    rise;
    logic          plus_ev, minus_ev, start_ev, clear_ev;
    logic          adj, step_up, step_dn, tick;
    logic [VW-1:0] dec_val;

    always_comb begin
        btn_d      = {clear, start, minus, plus};
        rise       = btn_d & ~btn_q;
        plus_ev    = rise[0];
        minus_ev   = rise[1];
        start_ev   = rise[2];
        clear_ev   = rise[3];

        state_d    = state_q;
        value_d    = value_q;
        preset_d   = preset_q;
        presc_d    = presc_q;
        rpt_d      = '0;
        rpt_fast_d = 1'b0;
        finish_d   = 1'b0;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        tick       = (presc_q == PW'(CLK_HZ - 1));
        dec_val    = bcd_dec(value_q);
        adj        = (state_q == S_IDLE) || (state_q == S_PAUSE);

        // Auto-repeat: first step on the edge, then after the delay, then at the rate.
        if (adj && !(plus && minus)) begin
            if (plus_ev || minus_ev) begin
                step_up = plus;
                step_dn = !plus;
            end else if (plus || minus) begin
                if ((!rpt_fast_q && rpt_q == RW'(REPEAT_DELAY - 1)) ||
                    ( rpt_fast_q && rpt_q == RW'(REPEAT_RATE - 1))) begin
                    step_up    = plus;
                    step_dn    = !plus;
                    rpt_fast_d = 1'b1;
                end else begin
                    rpt_d      = rpt_q + RW'(1);
                    rpt_fast_d = rpt_fast_q;
                end
            end
        end

        if (clear_ev) begin
            if (state_q == S_IDLE) begin
                value_d  = '0;
                preset_d = '0;
            end else begin
                state_d = S_IDLE;
                value_d = preset_q;
                presc_d = '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_ev && value_q != '0) begin
                        preset_d = value_q;
                        presc_d  = '0;
                        state_d  = S_RUN;
                    end else if (step_up) begin
                        value_d = bcd_inc(value_q);
                    end else if (step_dn) begin
                        value_d = dec_val;
                    end
                end
                S_RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) value_d = dec_val;
                    // Reaching zero beats a simultaneous pause request.
                    if (tick && dec_val == '0) begin
                        state_d  = S_DONE;
                        finish_d = 1'b1;
                    end else if (start_ev) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_ev && value_q != '0) begin
                        state_d = S_RUN;
                    end else if (step_up) begin
                        value_d = bcd_inc(value_q);
                    end else if (step_dn) begin
                        value_d = dec_val;
                    end
                end
                S_DONE: begin
                    if (plus_ev || minus_ev || start_ev) begin
                        state_d = S_IDLE;
                        value_d = preset_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            value_q    <= '0;
            preset_q   <= '0;
            presc_q    <= '0;
            rpt_q      <= '0;
            rpt_fast_q <= 1'b0;
            finish_q   <= 1'b0;
            btn_q      <= '0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            preset_q   <= preset_d;
            presc_q    <= presc_d;
            rpt_q      <= rpt_d;
            rpt_fast_q <= rpt_fast_d;
            finish_q   <= finish_d;
            btn_q      <= btn_d;
        end
    end

    assign display = value_q;
    assign running = (state_q == S_RUN);
    assign paused  = (state_q == S_PAUSE);
    assign done    = (state_q == S_DONE);
    assign finish  = finish_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: expected display values are queued as stimulus is applied and
// popped against the DUT; status flags are checked directly.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        plus, minus, start, clear;
    logic        fp, fm, zero_l;
    logic [15:0] a_disp, fm_disp, fd_disp;
    logic        a_run, a_pau, a_done, a_fin;
    logic        fm_run, fm_pau, fm_done, fm_fin;
    logic        fd_run, fd_pau, fd_done, fd_fin;

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(4), .MODE_MMSS(1), .CLK_HZ(10), .REPEAT_DELAY(20), .REPEAT_RATE(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .plus(plus), .minus(minus), .start(start), .clear(clear),
        .display(a_disp), .running(a_run), .paused(a_pau), .done(a_done), .finish(a_fin));

    bcd_countdown_timer #(.DIGITS(4), .MODE_MMSS(1), .CLK_HZ(10), .REPEAT_DELAY(2), .REPEAT_RATE(1)) u_fast_mmss (
        .clk(clk), .rst_n(rst_n), .plus(fp), .minus(fm), .start(zero_l), .clear(zero_l),
        .display(fm_disp), .running(fm_run), .paused(fm_pau), .done(fm_done), .finish(fm_fin));

    bcd_countdown_timer #(.DIGITS(4), .MODE_MMSS(0), .CLK_HZ(10), .REPEAT_DELAY(2), .REPEAT_RATE(1)) u_fast_dec (
        .clk(clk), .rst_n(rst_n), .plus(fp), .minus(fm), .start(zero_l), .clear(zero_l),
        .display(fd_disp), .running(fd_run), .paused(fd_pau), .done(fd_done), .finish(fd_fin));

    always @(negedge clk) if (a_fin) fin_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] v);
        sb_q.push_back('{tag, v});
    endtask

    task automatic sb_pop(input logic [15:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, {16'd0, act}, {16'd0, e.val});
        end
    endtask

    task automatic exp_disp(input string tag, input logic [15:0] v);
        sb_push(tag, v);
        sb_pop(a_disp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle level on {clear,start,minus,plus}, followed by one low cycle.
    task automatic press(input logic [3:0] m);
        {clear, start, minus, plus} = m;
        @(negedge clk);
        {clear, start, minus, plus} = 4'b0000;
        @(negedge clk);
    endtask

    function automatic logic [15:0] to_mmss(input int n);
        int m, s;
        m = n / 60;
        s = n % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int steps;
        rst_n = 1'b0;
        {clear, start, minus, plus} = 4'b0000;
        fp = 1'b0; fm = 1'b0; zero_l = 1'b0;
        wait_n(2);
        exp_disp("rst_disp", 16'h0000);
        chk("rst_flags", {a_run, a_pau, a_done, a_fin}, 4'b0000);
        rst_n = 1'b1;
        wait_n(1);

        // Saturation on the fast-repeat instances.
        fp = 1'b1;
        wait_n(10010);
        chk("sat_mmss", fm_disp, 16'h9959);
        chk("sat_dec", fd_disp, 16'h9999);
        fp = 1'b0;
        wait_n(2);
        fp = 1'b1; wait_n(1); fp = 1'b0; wait_n(1);
        chk("sat_mmss_plus", fm_disp, 16'h9959);
        chk("sat_dec_plus", fd_disp, 16'h9999);
        fp = 1'b1; fm = 1'b1;
        wait_n(20);
        chk("both_held", fd_disp, 16'h9999);
        fp = 1'b0; fm = 1'b0;
        wait_n(2);

        // Single step then a 1-second countdown.
        press(4'b0001);
        exp_disp("plus1", 16'h0001);
        press(4'b0100);
        chk("run1", a_run, 1'b1);
        wait_n(8);
        exp_disp("run1_pre", 16'h0001);
        chk("fin_pre", a_fin, 1'b0);
        wait_n(1);
        exp_disp("run1_zero", 16'h0000);
        chk("fin_pulse", {a_fin, a_done, a_run}, 3'b110);
        wait_n(1);
        chk("fin_gone", {a_fin, a_done}, 2'b01);
        chk("fin_cnt1", fin_cnt, 1);
        press(4'b1000);
        exp_disp("done_clear", 16'h0001);
        chk("done_clear_st", a_done, 1'b0);
        press(4'b1000);
        exp_disp("idle_clear", 16'h0000);
        press(4'b0010);
        exp_disp("minus_sat0", 16'h0000);

        // Auto-repeat up to 01:00.
        plus = 1'b1;
        for (int k = 0; k <= 310; k++) begin
            @(negedge clk);
            steps = (k < 20) ? 1 : 2 + (k - 20) / 5;
            sb_push("rpt", to_mmss(steps));
            sb_pop(a_disp);
        end
        plus = 1'b0;
        wait_n(2);
        exp_disp("rpt_release", 16'h0100);
        press(4'b0100);
        wait_n(8);
        exp_disp("mmss_pre", 16'h0100);
        wait_n(1);
        exp_disp("mmss_borrow", 16'h0059);
        press(4'b1000);
        exp_disp("run_clear", 16'h0100);
        chk("run_clear_st", a_run, 1'b0);
        press(4'b1000);
        exp_disp("clear0", 16'h0000);

        // Pause / resume with preset 00:05.
        repeat (5) press(4'b0001);
        exp_disp("preset5", 16'h0005);
        press(4'b0100);
        wait_n(11);
        exp_disp("pre_pause", 16'h0004);
        press(4'b0100);
        chk("paused", {a_pau, a_run}, 2'b10);
        wait_n(50);
        exp_disp("pause_hold", 16'h0004);
        press(4'b0100);
        chk("resumed", {a_pau, a_run}, 2'b01);
        wait_n(5);
        exp_disp("resume_pre", 16'h0004);
        wait_n(1);
        exp_disp("resume_dec", 16'h0003);
        press(4'b1000);
        exp_disp("clear_run3", 16'h0005);

        // Full run to DONE, then start restores preset.
        press(4'b0100);
        wait_n(48);
        exp_disp("done_pre", 16'h0001);
        wait_n(1);
        exp_disp("done_zero", 16'h0000);
        chk("done_st", {a_done, a_fin}, 2'b11);
        wait_n(2);
        press(4'b0100);
        exp_disp("done_start", 16'h0005);
        chk("done_start_st", {a_run, a_pau, a_done}, 3'b000);
        press(4'b1100);
        exp_disp("clr_start", 16'h0000);
        chk("clr_start_st", a_run, 1'b0);
        chk("fin_cnt2", fin_cnt, 2);

        // Asynchronous reset mid-run.
        repeat (3) press(4'b0001);
        press(4'b0100);
        wait_n(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_disp("arst_disp", 16'h0000);
        chk("arst_flags", {a_run, a_pau, a_done, a_fin}, 4'b0000);
        wait_n(2);
        rst_n = 1'b1;
        press(4'b0100);
        exp_disp("arst_start", 16'h0000);
        chk("arst_run", a_run, 1'b0);
        wait_n(20);
        chk("fin_cnt_arst", fin_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
